vga_pixel_fetch: RTL and testbench
==================================

// Module: vga_pixel_fetch
// PURPOSE
// Frame-buffer read master feeding the VGA scan-out path. Walks a linear frame of bytes from
// FrameBase, presents each address on the memory controller's read-address source 1 and holds
// it until that controller returns the byte with its ready strobe. Buffers returned bytes in a
// small FIFO and serves the pixel timing generator one byte per PixelReq.
// PARAMETERS
// AWIDTH      19      memory address width; matches memory controller
// DWIDTH      8       data width (one pixel per byte)
// FIFO_DEPTH  16      FIFO entries; power of 2, >=2
// FRAME_BYTES 307200  bytes per frame (640x480x8bpp); must be <= 2**AWIDTH
// PORTS
// MemClk       in   1            memory clock; all logic on posedge
// Reset        in   1            synchronous, active-high
// FrameStart   in   1            1-cycle pulse from timing gen: restart frame
// FrameBase    in   AWIDTH       frame start address, sampled on FrameStart
// ReqAddr      out  AWIDTH       read address to memory controller source 1
// ReadData     in   DWIDTH       byte returned by memory controller (read data 1)
// ReadDataRdy  in   1            1-cycle strobe: ReadData valid for ReqAddr
// PixelReq     in   1            pop request from timing gen (active area)
// PixelData    out  DWIDTH       popped pixel, registered
// PixelValid   out  1            PixelData valid this cycle
// FifoLevel    out  log2(D)+1    current FIFO occupancy 0..FIFO_DEPTH
// Busy         out  1            high while state==FETCH
// Underflow    out  1            sticky: PixelReq seen with FIFO empty
// BEHAVIOUR
// - Reset: state IDLE, ReqAddr=0, byte counter=0, FIFO flushed (rd/wr ptr 0, FifoLevel=0),
//   PixelData=0, PixelValid=0, Busy=0, Underflow=0. Reset dominates every other input.
// - States: IDLE (after reset, no fetch), FETCH, DONE (frame fully fetched).
//   IDLE/FETCH/DONE --FrameStart--> FETCH: ReqAddr<=FrameBase, counter<=0, FIFO flushed
//   same edge (FifoLevel=0 next cycle); pending ReadDataRdy on that edge is discarded.
//   FETCH --accept of byte with counter==FRAME_BYTES-1--> DONE. DONE holds ReqAddr.
// - Accept: in FETCH, ReadDataRdy=1 and (FIFO not full or pop this cycle) -> ReadData written
//   at wr ptr; ReqAddr<=ReqAddr+1 (wraps mod 2**AWIDTH), counter<=counter+1, both same edge.
// - Reject: ReadDataRdy=1 while full and no pop, or in IDLE/DONE -> byte dropped, ReqAddr
//   unchanged; controller re-reads same address in its next slot. No byte ever skipped/duped.
// - ReqAddr changes only on accept or FrameStart, so it is stable across the controller's
//   address-sample/data-return window.
// - Pop: PixelReq=1 with FifoLevel>0 -> next cycle PixelData=head byte, PixelValid=1
//   (1-cycle latency). PixelReq=1 with FifoLevel==0 -> next cycle PixelData=0, PixelValid=0,
//   Underflow<=1. No bypass: push+pop on empty FIFO is an underflow; pushed byte is stored.
// - PixelReq=0 -> PixelValid=0 next cycle, PixelData holds last value.
// - Simultaneous push+pop, FIFO non-empty: FifoLevel unchanged, both pointers advance
//   (mod FIFO_DEPTH). Full FIFO + pop + push accepted.
// - PixelReq and FrameStart same edge: FrameStart wins, no pop, PixelValid=0.
// - Underflow clears only on Reset (not on FrameStart).
// - Busy = (state==FETCH), registered with state.
// TESTING (bench: FIFO_DEPTH=4, FRAME_BYTES=8, AWIDTH=19)
// 1 Reset mid-FETCH with FifoLevel=3 -> next cycle ReqAddr=0, FifoLevel=0, Busy=0, PixelValid=0.
// 2 FrameStart, FrameBase=0x100; memory model returns addr[7:0] each strobe, no PixelReq ->
//   ReqAddr steps 0x100..0x104, FIFO fills 0x00..0x03, further strobes rejected, ReqAddr stays 0x104.
// 3 From (2) pop one (PixelReq 1 cycle) with strobe same edge -> PixelData=0x00, PixelValid=1,
//   FifoLevel stays 4, ReqAddr=0x105; subsequent pops yield 0x01,0x02,0x03,0x04 in order.
// 4 Continuous pops, strobe every cycle -> 8 bytes 0x00..0x07 out, state DONE after 8th accept,
//   Busy=0, ReqAddr=0x108 held; further strobes ignored.
// 5 PixelReq with FIFO empty -> PixelValid=0, PixelData=0, Underflow=1; stays 1 after FrameStart.
// 6 FrameStart mid-frame with FifoLevel=2 and strobe same edge -> FifoLevel=0, ReqAddr=FrameBase,
//   stale byte not stored; next accepted byte is from FrameBase.

Source files
------------

// File: rtl/vga_pixel_fetch_if.sv
// Bundle of frame-control, memory read and pixel pop signals for the VGA pixel fetcher.
// The master modport is the fetcher; the slave modport is its environment.
interface vga_pixel_fetch_if #(
  parameter int AWIDTH     = 19,
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LWIDTH = $clog2(FIFO_DEPTH) + 1;

  logic              frame_start;
  logic [AWIDTH-1:0] frame_base;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] read_data;
  logic              read_data_rdy;
  logic              pixel_req;
  logic [DWIDTH-1:0] pixel_data;
  logic              pixel_valid;
  logic [LWIDTH-1:0] fifo_level;
  logic              busy;
  logic              underflow;

  modport master (
    input  frame_start, frame_base, read_data, read_data_rdy, pixel_req,
    output req_addr, pixel_data, pixel_valid, fifo_level, busy, underflow
  );

  modport slave (
    output frame_start, frame_base, read_data, read_data_rdy, pixel_req,
    input  req_addr, pixel_data, pixel_valid, fifo_level, busy, underflow
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Frame-buffer read master: walks a frame linearly, holds each address until its byte is
// accepted into a small FIFO, and pops one pixel per request with one cycle of latency.
module vga_pixel_fetch #(
  parameter int AWIDTH      = 19,
  parameter int DWIDTH      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_BYTES = 307200
) (
  input logic                 i_mem_clk,
  input logic                 i_reset,
  vga_pixel_fetch_if.master   io_fetch
);
  localparam int PWIDTH = $clog2(FIFO_DEPTH);
  localparam int LWIDTH = PWIDTH + 1;
  localparam int CWIDTH = $clog2(FRAME_BYTES + 1);
  localparam logic [CWIDTH-1:0] LAST_CNT   = CWIDTH'(FRAME_BYTES - 1);
  localparam logic [LWIDTH-1:0] FULL_LEVEL = LWIDTH'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [AWIDTH-1:0]  r_req_addr;
  logic [CWIDTH-1:0]  r_cnt;
  logic [PWIDTH-1:0]  r_wr_ptr;
  logic [PWIDTH-1:0]  r_rd_ptr;
  logic [LWIDTH-1:0]  r_level;
  logic [DWIDTH-1:0]  r_pixel_data;
  logic               r_pixel_valid;
  logic               r_busy;
  logic               r_underflow;
  logic [DWIDTH-1:0]  r_mem [FIFO_DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // FrameStart overrides both the pop and the push on the same edge.
  assign w_empty = (r_level == LWIDTH'(0));
  assign w_full  = (r_level == FULL_LEVEL);
  assign w_pop   = io_fetch.pixel_req && !io_fetch.frame_start && !w_empty;
  assign w_push  = (r_state == ST_FETCH) && io_fetch.read_data_rdy && !io_fetch.frame_start &&
                   (!w_full || w_pop);

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge i_mem_clk) begin
    if (w_push && !i_reset) begin
      r_mem[r_wr_ptr] <= io_fetch.read_data;
    end
  end

  // Fetch state machine, address/counter, FIFO pointers and pixel output registers.
  always_ff @(posedge i_mem_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_req_addr    <= '0;
      r_cnt         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_pixel_data  <= '0;
      r_pixel_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_underflow   <= 1'b0;
    end else if (io_fetch.frame_start) begin
      r_state       <= ST_FETCH;
      r_req_addr    <= io_fetch.frame_base;
      r_cnt         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_pixel_valid <= 1'b0;
      r_busy        <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PWIDTH'(1);
        r_req_addr <= r_req_addr + AWIDTH'(1);
        r_cnt      <= r_cnt + CWIDTH'(1);
        if (r_cnt == LAST_CNT) begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
        end
      end

      if (w_pop) begin
        r_pixel_data  <= r_mem[r_rd_ptr];
        r_pixel_valid <= 1'b1;
        r_rd_ptr      <= r_rd_ptr + PWIDTH'(1);
      end else if (io_fetch.pixel_req) begin
        r_pixel_data  <= '0;
        r_pixel_valid <= 1'b0;
        r_underflow   <= 1'b1;
      end else begin
        r_pixel_valid <= 1'b0;
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LWIDTH'(1);
        2'b01:   r_level <= r_level - LWIDTH'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign io_fetch.req_addr    = r_req_addr;
  assign io_fetch.pixel_data  = r_pixel_data;
  assign io_fetch.pixel_valid = r_pixel_valid;
  assign io_fetch.fifo_level  = r_level;
  assign io_fetch.busy        = r_busy;
  assign io_fetch.underflow   = r_underflow;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch with a 4-entry FIFO and an 8-byte frame;
// the memory model returns the low byte of the requested address.
module tb_vga_pixel_fetch;
  localparam int AWIDTH      = 19;
  localparam int DWIDTH      = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int FRAME_BYTES = 8;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  vga_pixel_fetch_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  vga_pixel_fetch #(
    .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH), .FRAME_BYTES(FRAME_BYTES)
  ) dut (
    .i_mem_clk (clk),
    .i_reset   (reset),
    .io_fetch  (bus.master)
  );

  assign bus.read_data = bus.req_addr[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset             = 1'b1;
    bus.frame_start   = 1'b0;
    bus.frame_base    = '0;
    bus.read_data_rdy = 1'b0;
    bus.pixel_req     = 1'b0;

    tick();
    chk("rst_addr",  32'(bus.req_addr),    32'h0);
    chk("rst_level", 32'(bus.fifo_level),  32'h0);
    chk("rst_busy",  32'(bus.busy),        32'h0);
    chk("rst_valid", 32'(bus.pixel_valid), 32'h0);
    chk("rst_data",  32'(bus.pixel_data),  32'h0);
    chk("rst_uflow", 32'(bus.underflow),   32'h0);
    reset = 1'b0;

    // 1: reset mid-fetch with three bytes buffered
    bus.frame_start = 1'b1;
    bus.frame_base  = 19'h40;
    tick();
    bus.frame_start   = 1'b0;
    bus.read_data_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t1_level", 32'(bus.fifo_level), 32'h3);
    chk("t1_addr",  32'(bus.req_addr),   32'h43);
    chk("t1_busy",  32'(bus.busy),       32'h1);
    reset         = 1'b1;
    bus.pixel_req = 1'b1;
    tick();
    chk("t1_rst_addr",  32'(bus.req_addr),    32'h0);
    chk("t1_rst_level", 32'(bus.fifo_level),  32'h0);
    chk("t1_rst_busy",  32'(bus.busy),        32'h0);
    chk("t1_rst_valid", 32'(bus.pixel_valid), 32'h0);
    reset             = 1'b0;
    bus.pixel_req     = 1'b0;
    bus.read_data_rdy = 1'b0;
    tick();

    // 2: fill the FIFO from 0x100, then strobes are rejected
    bus.frame_start = 1'b1;
    bus.frame_base  = 19'h100;
    tick();
    chk("t2_start_addr",  32'(bus.req_addr),   32'h100);
    chk("t2_start_level", 32'(bus.fifo_level), 32'h0);
    chk("t2_start_busy",  32'(bus.busy),       32'h1);
    bus.frame_start   = 1'b0;
    bus.read_data_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_fill_addr",  32'(bus.req_addr),   32'h101 + 32'(i));
      chk("t2_fill_level", 32'(bus.fifo_level), 32'(i + 1));
    end
    tick();
    tick();
    chk("t2_full_addr",  32'(bus.req_addr),   32'h104);
    chk("t2_full_level", 32'(bus.fifo_level), 32'h4);

    // 3: pop on full with a strobe on the same edge
    bus.pixel_req = 1'b1;
    tick();
    chk("t3_data",  32'(bus.pixel_data),  32'h00);
    chk("t3_valid", 32'(bus.pixel_valid), 32'h1);
    chk("t3_level", 32'(bus.fifo_level),  32'h4);
    chk("t3_addr",  32'(bus.req_addr),    32'h105);

    // 4: continuous pops and strobes drain the rest of the frame
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("t4_data",  32'(bus.pixel_data),  32'(i));
      chk("t4_valid", 32'(bus.pixel_valid), 32'h1);
      if (i == 3) begin
        chk("t4_done_busy", 32'(bus.busy),     32'h0);
        chk("t4_done_addr", 32'(bus.req_addr), 32'h108);
      end
    end
    chk("t4_end_level", 32'(bus.fifo_level), 32'h0);
    chk("t4_end_addr",  32'(bus.req_addr),   32'h108);
    chk("t4_end_uflow", 32'(bus.underflow),  32'h0);

    // 5: pop on empty raises sticky underflow
    tick();
    chk("t5_valid", 32'(bus.pixel_valid), 32'h0);
    chk("t5_data",  32'(bus.pixel_data),  32'h0);
    chk("t5_uflow", 32'(bus.underflow),   32'h1);
    chk("t5_level", 32'(bus.fifo_level),  32'h0);
    bus.pixel_req     = 1'b0;
    bus.read_data_rdy = 1'b0;
    bus.frame_start   = 1'b1;
    bus.frame_base    = 19'h250;
    tick();
    chk("t5_fs_uflow", 32'(bus.underflow), 32'h1);
    chk("t5_fs_addr",  32'(bus.req_addr),  32'h250);
    chk("t5_fs_busy",  32'(bus.busy),      32'h1);

    // 6: restart mid-frame with two buffered bytes, a stale strobe and a pop request
    bus.frame_start   = 1'b0;
    bus.read_data_rdy = 1'b1;
    tick();
    tick();
    chk("t6_pre_level", 32'(bus.fifo_level), 32'h2);
    chk("t6_pre_addr",  32'(bus.req_addr),   32'h252);
    bus.frame_start = 1'b1;
    bus.frame_base  = 19'h3A5;
    bus.pixel_req   = 1'b1;
    tick();
    chk("t6_fs_level", 32'(bus.fifo_level),  32'h0);
    chk("t6_fs_addr",  32'(bus.req_addr),    32'h3A5);
    chk("t6_fs_valid", 32'(bus.pixel_valid), 32'h0);
    bus.frame_start = 1'b0;
    bus.pixel_req   = 1'b0;
    tick();
    chk("t6_acc_level", 32'(bus.fifo_level), 32'h1);
    chk("t6_acc_addr",  32'(bus.req_addr),   32'h3A6);
    bus.read_data_rdy = 1'b0;
    bus.pixel_req     = 1'b1;
    tick();
    chk("t6_pop_data",  32'(bus.pixel_data),  32'hA5);
    chk("t6_pop_valid", 32'(bus.pixel_valid), 32'h1);
    chk("t6_pop_level", 32'(bus.fifo_level),  32'h0);
    bus.pixel_req = 1'b0;
    tick();
    chk("t6_idle_valid", 32'(bus.pixel_valid), 32'h0);
    chk("t6_idle_data",  32'(bus.pixel_data),  32'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
